// File: rtl/bp_be_pkg.sv
// Shared D$ engine types: request/command/packet structs, opcodes and FSM states.
package bp_be_pkg;

  localparam int paddr_width_p  = 40;
  localparam int sets_p         = 64;
  localparam int assoc_p        = 8;
  localparam int block_width_p  = 512;
  localparam int fill_width_p   = 64;
  localparam int credits_p      = 4;
  localparam int req_id_width_p = 2;

  localparam int block_offset_width_lp = $clog2(block_width_p/8);
  localparam int fill_bytes_width_lp   = $clog2(fill_width_p/8);
  localparam int index_width_lp        = $clog2(sets_p);
  localparam int way_width_lp          = $clog2(assoc_p);
  localparam int beats_lp              = block_width_p/fill_width_p;
  localparam int beat_width_lp         = $clog2(beats_lp);
  localparam int tag_width_lp          = paddr_width_p - index_width_lp - block_offset_width_lp;
  localparam logic [2:0] block_size_lp = 3'(block_offset_width_lp);

  typedef enum logic [1:0] {e_miss_load, e_miss_store, e_uc_load, e_uc_store} bp_be_dcache_req_type_e;
  typedef enum logic [1:0] {e_mem_rd_block, e_mem_uc_rd, e_mem_uc_wr} bp_be_mem_cmd_opcode_e;
  typedef enum logic {e_data_mem_write, e_data_mem_uncached} bp_be_data_mem_opcode_e;
  typedef enum logic {e_tag_set_tag} bp_be_tag_mem_opcode_e;
  typedef enum logic {e_stat_set_lru} bp_be_stat_mem_opcode_e;
  typedef enum logic {e_coh_invalid, e_coh_valid} bp_be_coh_state_e;
  typedef enum logic [2:0] {e_ready, e_meta, e_cmd, e_fill, e_tag, e_stat} bp_be_miss_state_e;

  // size is log2(bytes) throughout
  typedef struct packed {
    bp_be_dcache_req_type_e   msg_type;
    logic [paddr_width_p-1:0] addr;
    logic [2:0]               size;
    logic [fill_width_p-1:0]  data;
  } bp_be_dcache_req_s;

  typedef struct packed {
    bp_be_mem_cmd_opcode_e    opcode;
    logic [paddr_width_p-1:0] addr;
    logic [2:0]               size;
    logic [fill_width_p-1:0]  data;
  } bp_be_mem_cmd_s;

  typedef struct packed {
    logic [index_width_lp-1:0] index;
    logic [way_width_lp-1:0]   way;
    logic [beat_width_lp-1:0]  fill_index;
    bp_be_data_mem_opcode_e    opcode;
    logic [fill_width_p-1:0]   data;
  } bp_be_data_mem_pkt_s;

  typedef struct packed {
    logic [index_width_lp-1:0] index;
    logic [way_width_lp-1:0]   way;
    logic [tag_width_lp-1:0]   tag;
    bp_be_coh_state_e          state;
    bp_be_tag_mem_opcode_e     opcode;
  } bp_be_tag_mem_pkt_s;

  typedef struct packed {
    logic [index_width_lp-1:0] index;
    logic [way_width_lp-1:0]   way;
    bp_be_stat_mem_opcode_e    opcode;
  } bp_be_stat_mem_pkt_s;

endpackage

// File: rtl/bp_be_dcache_miss_engine_if.sv
// D$ <-> miss engine <-> memory bundle. slave = engine view, master = D$/memory view.
interface bp_be_dcache_miss_engine_if;
  import bp_be_pkg::*;

  bp_be_dcache_req_s            cache_req_i;
  logic                         cache_req_v_i;
  logic                         cache_req_yumi_o;
  logic                         cache_req_lock_o;
  logic [way_width_lp-1:0]      cache_req_metadata_i;
  logic                         cache_req_metadata_v_i;
  logic [req_id_width_p-1:0]    cache_req_id_o;
  logic                         cache_req_critical_o;
  logic                         cache_req_last_o;
  logic                         cache_req_credits_full_o;
  logic                         cache_req_credits_empty_o;

  bp_be_mem_cmd_s               mem_cmd_o;
  logic                         mem_cmd_v_o;
  logic                         mem_cmd_ready_and_i;
  logic [fill_width_p-1:0]      mem_resp_data_i;
  logic                         mem_resp_v_i;
  logic                         mem_resp_yumi_o;

  bp_be_data_mem_pkt_s          data_mem_pkt_o;
  logic                         data_mem_pkt_v_o;
  logic                         data_mem_pkt_yumi_i;
  bp_be_tag_mem_pkt_s           tag_mem_pkt_o;
  logic                         tag_mem_pkt_v_o;
  logic                         tag_mem_pkt_yumi_i;
  bp_be_stat_mem_pkt_s          stat_mem_pkt_o;
  logic                         stat_mem_pkt_v_o;
  logic                         stat_mem_pkt_yumi_i;

  modport slave (
    input  cache_req_i, cache_req_v_i, cache_req_metadata_i, cache_req_metadata_v_i,
           mem_cmd_ready_and_i, mem_resp_data_i, mem_resp_v_i,
           data_mem_pkt_yumi_i, tag_mem_pkt_yumi_i, stat_mem_pkt_yumi_i,
    output cache_req_yumi_o, cache_req_lock_o, cache_req_id_o, cache_req_critical_o,
           cache_req_last_o, cache_req_credits_full_o, cache_req_credits_empty_o,
           mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o,
           data_mem_pkt_o, data_mem_pkt_v_o, tag_mem_pkt_o, tag_mem_pkt_v_o,
           stat_mem_pkt_o, stat_mem_pkt_v_o
  );

  modport master (
    output cache_req_i, cache_req_v_i, cache_req_metadata_i, cache_req_metadata_v_i,
           mem_cmd_ready_and_i, mem_resp_data_i, mem_resp_v_i,
           data_mem_pkt_yumi_i, tag_mem_pkt_yumi_i, stat_mem_pkt_yumi_i,
    input  cache_req_yumi_o, cache_req_lock_o, cache_req_id_o, cache_req_critical_o,
           cache_req_last_o, cache_req_credits_full_o, cache_req_credits_empty_o,
           mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o,
           data_mem_pkt_o, data_mem_pkt_v_o, tag_mem_pkt_o, tag_mem_pkt_v_o,
           stat_mem_pkt_o, stat_mem_pkt_v_o
  );
endinterface

// File: rtl/bp_be_credit_counter.sv
// Outstanding memory command tracker: +1 per issued command, -1 per retired one.
module bp_be_credit_counter #(
  parameter int credits_p = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);
  localparam int width_lp = $clog2(credits_p+1);

  logic [width_lp-1:0] count_r;

  // simultaneous inc/dec cancel; a stray dec at zero is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count_r <= '0;
    else if (inc && !dec && !full) count_r <= count_r + width_lp'(1);
    else if (dec && !inc && !empty) count_r <= count_r - width_lp'(1);
  end

  assign full  = (count_r == width_lp'(credits_p));
  assign empty = (count_r == '0);
endmodule

// File: rtl/bp_be_dcache_miss_engine.sv
// Write-through D$ miss engine: one outstanding read, posted stores limited by credits.
module bp_be_dcache_miss_engine
  import bp_be_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_be_dcache_miss_engine_if.slave eng
);

  bp_be_miss_state_e          state_r, state_n;
  bp_be_dcache_req_s          req_r;
  logic [way_width_lp-1:0]    way_r;
  logic [req_id_width_p-1:0]  id_r;
  logic [beat_width_lp-1:0]   beat_r;

  logic req_fire, cmd_fire, beat_fire, ack_fire, last_beat;
  logic is_store, is_uc_load, credits_full, credits_empty;
  logic [index_width_lp-1:0]  index;
  logic [beat_width_lp-1:0]   crit_beat;

  bp_be_mem_cmd_s      mem_cmd;
  bp_be_data_mem_pkt_s data_pkt;
  bp_be_tag_mem_pkt_s  tag_pkt;
  bp_be_stat_mem_pkt_s stat_pkt;

  assign is_store   = (req_r.msg_type == e_miss_store) || (req_r.msg_type == e_uc_store);
  assign is_uc_load = (req_r.msg_type == e_uc_load);
  assign index      = req_r.addr[block_offset_width_lp +: index_width_lp];
  assign crit_beat  = req_r.addr[fill_bytes_width_lp +: beat_width_lp];

  // reset gates the combinational yumis so nothing is consumed while held in reset
  assign req_fire  = reset_n_i && (state_r == e_ready) && eng.cache_req_v_i && !credits_full;
  assign cmd_fire  = (state_r == e_cmd) && eng.mem_cmd_ready_and_i;
  assign beat_fire = (state_r == e_fill) && eng.mem_resp_v_i && eng.data_mem_pkt_yumi_i;
  // in-order responses and a single outstanding read: anything outside a fill is a store ack
  assign ack_fire  = reset_n_i && (state_r != e_fill) && eng.mem_resp_v_i;
  // beats_lp is a power of two, so the final beat is the all-ones count
  assign last_beat = is_uc_load || (&beat_r);

  bp_be_credit_counter #(.credits_p(credits_p)) credits (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .inc   (cmd_fire),
    .dec   (ack_fire || (beat_fire && last_beat)),
    .full  (credits_full),
    .empty (credits_empty)
  );

  // state, id and latched request; everything in flight is dropped on reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      req_r   <= '0;
      way_r   <= '0;
      id_r    <= '0;
      beat_r  <= '0;
    end else begin
      state_r <= state_n;
      if (req_fire) begin
        req_r  <= eng.cache_req_i;
        id_r   <= id_r + 1'b1;
        beat_r <= '0;
      end
      if (state_r == e_meta && eng.cache_req_metadata_v_i) way_r <= eng.cache_req_metadata_i;
      if (beat_fire) beat_r <= beat_r + 1'b1;
    end
  end

  // next state and packet contents
  always_comb begin
    state_n = state_r;

    mem_cmd.opcode = e_mem_uc_wr;
    mem_cmd.addr   = req_r.addr;
    mem_cmd.size   = req_r.size;
    mem_cmd.data   = req_r.data;
    if (req_r.msg_type == e_miss_load) begin
      // block read, but the address keeps the critical beat so memory returns it first
      mem_cmd.opcode = e_mem_rd_block;
      mem_cmd.addr   = {req_r.addr[paddr_width_p-1:fill_bytes_width_lp], {fill_bytes_width_lp{1'b0}}};
      mem_cmd.size   = block_size_lp;
    end else if (is_uc_load) begin
      mem_cmd.opcode = e_mem_uc_rd;
    end

    data_pkt.index      = index;
    data_pkt.way        = way_r;
    data_pkt.fill_index = crit_beat + beat_r;
    data_pkt.opcode     = e_data_mem_write;
    if (is_uc_load) data_pkt.opcode = e_data_mem_uncached;
    data_pkt.data       = eng.mem_resp_data_i;

    tag_pkt.index  = index;
    tag_pkt.way    = way_r;
    tag_pkt.tag    = req_r.addr[paddr_width_p-1 -: tag_width_lp];
    tag_pkt.state  = e_coh_valid;
    tag_pkt.opcode = e_tag_set_tag;

    stat_pkt.index  = index;
    stat_pkt.way    = way_r;
    stat_pkt.opcode = e_stat_set_lru;

    unique case (state_r)
      e_ready: if (req_fire) begin
        if (eng.cache_req_i.msg_type == e_miss_load) state_n = e_meta;
        else                                         state_n = e_cmd;
      end
      e_meta:  if (eng.cache_req_metadata_v_i) state_n = e_cmd;
      e_cmd:   if (cmd_fire) begin
        if (is_store) state_n = e_ready;
        else          state_n = e_fill;
      end
      e_fill:  if (beat_fire && last_beat) begin
        if (is_uc_load) state_n = e_ready;
        else            state_n = e_tag;
      end
      e_tag:   if (eng.tag_mem_pkt_yumi_i)  state_n = e_stat;
      e_stat:  if (eng.stat_mem_pkt_yumi_i) state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  assign eng.cache_req_yumi_o          = req_fire;
  assign eng.cache_req_lock_o          = (state_r != e_ready);
  assign eng.cache_req_id_o            = id_r;
  assign eng.cache_req_critical_o      = beat_fire && (beat_r == '0);
  assign eng.cache_req_last_o          = beat_fire && last_beat;
  assign eng.cache_req_credits_full_o  = credits_full;
  assign eng.cache_req_credits_empty_o = credits_empty;

  assign eng.mem_cmd_o        = mem_cmd;
  assign eng.mem_cmd_v_o      = (state_r == e_cmd);
  assign eng.mem_resp_yumi_o  = ack_fire || beat_fire;

  assign eng.data_mem_pkt_o   = data_pkt;
  assign eng.data_mem_pkt_v_o = (state_r == e_fill) && eng.mem_resp_v_i;
  assign eng.tag_mem_pkt_o    = tag_pkt;
  assign eng.tag_mem_pkt_v_o  = (state_r == e_tag);
  assign eng.stat_mem_pkt_o   = stat_pkt;
  assign eng.stat_mem_pkt_v_o = (state_r == e_stat);

endmodule

// File: tb/tb_bp_be_dcache_miss_engine.sv
// Directed bench for the D$ miss engine: fills, uncached loads, store credits, reset.
module tb_bp_be_dcache_miss_engine;
  import bp_be_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bp_be_dcache_miss_engine_if bus ();

  bp_be_dcache_miss_engine dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .eng       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.cache_req_v_i          = 1'b0;
    bus.cache_req_i            = '0;
    bus.cache_req_metadata_v_i = 1'b0;
    bus.cache_req_metadata_i   = '0;
    bus.mem_cmd_ready_and_i    = 1'b0;
    bus.mem_resp_v_i           = 1'b0;
    bus.mem_resp_data_i        = '0;
    bus.data_mem_pkt_yumi_i    = 1'b0;
    bus.tag_mem_pkt_yumi_i     = 1'b0;
    bus.stat_mem_pkt_yumi_i    = 1'b0;
  endtask

  function automatic bp_be_dcache_req_s mk_req(input bp_be_dcache_req_type_e t,
                                               input logic [paddr_width_p-1:0] a,
                                               input logic [fill_width_p-1:0] d);
    bp_be_dcache_req_s r;
    r.msg_type = t;
    r.addr     = a;
    r.size     = 3'd3;
    r.data     = d;
    return r;
  endfunction

  initial begin
    // ---------------- reset, with inputs asserted to prove yumis stay low
    rst_n = 1'b0;
    idle();
    bus.cache_req_v_i = 1'b1;
    bus.cache_req_i   = mk_req(e_uc_store, 40'h100, 64'h1);
    bus.mem_resp_v_i  = 1'b1;
    cyc(); cyc(); #1;
    chk("rst_lock", 64'(bus.cache_req_lock_o), 64'd0);
    chk("rst_empty", 64'(bus.cache_req_credits_empty_o), 64'd1);
    chk("rst_full", 64'(bus.cache_req_credits_full_o), 64'd0);
    chk("rst_id", 64'(bus.cache_req_id_o), 64'd0);
    chk("rst_req_yumi", 64'(bus.cache_req_yumi_o), 64'd0);
    chk("rst_resp_yumi", 64'(bus.mem_resp_yumi_o), 64'd0);
    chk("rst_cmd_v", 64'(bus.mem_cmd_v_o), 64'd0);
    chk("rst_data_v", 64'(bus.data_mem_pkt_v_o), 64'd0);
    chk("rst_tag_v", 64'(bus.tag_mem_pkt_v_o), 64'd0);
    chk("rst_stat_v", 64'(bus.stat_mem_pkt_v_o), 64'd0);
    chk("rst_crit", 64'(bus.cache_req_critical_o), 64'd0);
    chk("rst_last", 64'(bus.cache_req_last_o), 64'd0);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();

    // ---------------- load miss at 0x8000_0058, victim way 3
    bus.cache_req_v_i = 1'b1;
    bus.cache_req_i   = mk_req(e_miss_load, 40'h00_8000_0058, 64'h0);
    #1 chk("miss_yumi", 64'(bus.cache_req_yumi_o), 64'd1);
    cyc();
    bus.cache_req_v_i          = 1'b0;
    bus.cache_req_metadata_v_i = 1'b1;
    bus.cache_req_metadata_i   = 3'd3;
    #1;
    chk("meta_lock", 64'(bus.cache_req_lock_o), 64'd1);
    chk("meta_id", 64'(bus.cache_req_id_o), 64'd1);
    chk("meta_cmd_v", 64'(bus.mem_cmd_v_o), 64'd0);
    cyc();
    bus.cache_req_metadata_v_i = 1'b0;
    #1;
    chk("miss_cmd_v", 64'(bus.mem_cmd_v_o), 64'd1);
    chk("miss_cmd_op", 64'(bus.mem_cmd_o.opcode), 64'(e_mem_rd_block));
    chk("miss_cmd_addr", 64'(bus.mem_cmd_o.addr), 64'h00_8000_0058);
    chk("miss_cmd_size", 64'(bus.mem_cmd_o.size), 64'd6);
    cyc();
    #1 chk("miss_cmd_hold", 64'(bus.mem_cmd_v_o), 64'd1);
    bus.mem_cmd_ready_and_i = 1'b1;
    cyc();
    bus.mem_cmd_ready_and_i = 1'b0;
    #1;
    chk("fill_cmd_v", 64'(bus.mem_cmd_v_o), 64'd0);
    chk("fill_empty", 64'(bus.cache_req_credits_empty_o), 64'd0);

    for (int n = 0; n < 8; n++) begin
      bus.mem_resp_v_i    = 1'b1;
      bus.mem_resp_data_i = 64'hA0 + 64'(n);
      if (n == 4) begin
        bus.data_mem_pkt_yumi_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("stall_v", 64'(bus.data_mem_pkt_v_o), 64'd1);
          chk("stall_idx", 64'(bus.data_mem_pkt_o.fill_index), 64'd7);
          chk("stall_resp_yumi", 64'(bus.mem_resp_yumi_o), 64'd0);
          cyc();
        end
      end
      bus.data_mem_pkt_yumi_i = 1'b1;
      #1;
      chk($sformatf("fill_idx%0d", n), 64'(bus.data_mem_pkt_o.fill_index), 64'((3 + n) % 8));
      chk($sformatf("fill_data%0d", n), 64'(bus.data_mem_pkt_o.data), 64'hA0 + 64'(n));
      chk($sformatf("fill_yumi%0d", n), 64'(bus.mem_resp_yumi_o), 64'd1);
      chk($sformatf("fill_crit%0d", n), 64'(bus.cache_req_critical_o), 64'(n == 0));
      chk($sformatf("fill_last%0d", n), 64'(bus.cache_req_last_o), 64'(n == 7));
      if (n == 0) begin
        chk("fill_op", 64'(bus.data_mem_pkt_o.opcode), 64'(e_data_mem_write));
        chk("fill_way", 64'(bus.data_mem_pkt_o.way), 64'd3);
        chk("fill_index", 64'(bus.data_mem_pkt_o.index), 64'd1);
      end
      cyc();
    end
    bus.mem_resp_v_i        = 1'b0;
    bus.data_mem_pkt_yumi_i = 1'b0;
    #1;
    chk("tag_v", 64'(bus.tag_mem_pkt_v_o), 64'd1);
    chk("tag_index", 64'(bus.tag_mem_pkt_o.index), 64'd1);
    chk("tag_way", 64'(bus.tag_mem_pkt_o.way), 64'd3);
    chk("tag_tag", 64'(bus.tag_mem_pkt_o.tag), 64'h0080000);
    chk("tag_state", 64'(bus.tag_mem_pkt_o.state), 64'(e_coh_valid));
    chk("tag_data_v", 64'(bus.data_mem_pkt_v_o), 64'd0);
    chk("tag_empty", 64'(bus.cache_req_credits_empty_o), 64'd1);
    bus.tag_mem_pkt_yumi_i = 1'b1;
    cyc();
    bus.tag_mem_pkt_yumi_i = 1'b0;
    #1;
    chk("stat_v", 64'(bus.stat_mem_pkt_v_o), 64'd1);
    chk("stat_tag_v", 64'(bus.tag_mem_pkt_v_o), 64'd0);
    chk("stat_way", 64'(bus.stat_mem_pkt_o.way), 64'd3);
    chk("stat_lock", 64'(bus.cache_req_lock_o), 64'd1);
    bus.stat_mem_pkt_yumi_i = 1'b1;
    cyc();
    bus.stat_mem_pkt_yumi_i = 1'b0;
    #1;
    chk("done_lock", 64'(bus.cache_req_lock_o), 64'd0);
    chk("done_stat_v", 64'(bus.stat_mem_pkt_v_o), 64'd0);

    // ---------------- uncached load at 0x1000
    bus.cache_req_v_i = 1'b1;
    bus.cache_req_i   = mk_req(e_uc_load, 40'h1000, 64'h0);
    #1 chk("uc_yumi", 64'(bus.cache_req_yumi_o), 64'd1);
    cyc();
    bus.cache_req_v_i = 1'b0;
    #1;
    chk("uc_cmd_v", 64'(bus.mem_cmd_v_o), 64'd1);
    chk("uc_cmd_op", 64'(bus.mem_cmd_o.opcode), 64'(e_mem_uc_rd));
    chk("uc_cmd_addr", 64'(bus.mem_cmd_o.addr), 64'h1000);
    chk("uc_id", 64'(bus.cache_req_id_o), 64'd2);
    bus.mem_cmd_ready_and_i = 1'b1;
    cyc();
    bus.mem_cmd_ready_and_i = 1'b0;
    bus.mem_resp_v_i        = 1'b1;
    bus.mem_resp_data_i     = 64'hDEAD_BEEF_0123_4567;
    bus.data_mem_pkt_yumi_i = 1'b1;
    #1;
    chk("uc_data_v", 64'(bus.data_mem_pkt_v_o), 64'd1);
    chk("uc_op", 64'(bus.data_mem_pkt_o.opcode), 64'(e_data_mem_uncached));
    chk("uc_data", 64'(bus.data_mem_pkt_o.data), 64'hDEAD_BEEF_0123_4567);
    chk("uc_crit", 64'(bus.cache_req_critical_o), 64'd1);
    chk("uc_last", 64'(bus.cache_req_last_o), 64'd1);
    cyc();
    idle();
    #1;
    chk("uc_done_lock", 64'(bus.cache_req_lock_o), 64'd0);
    chk("uc_no_tag", 64'(bus.tag_mem_pkt_v_o), 64'd0);
    chk("uc_no_stat", 64'(bus.stat_mem_pkt_v_o), 64'd0);
    chk("uc_empty", 64'(bus.cache_req_credits_empty_o), 64'd1);

    // ---------------- four posted stores with no acks fill the credits
    bus.mem_cmd_ready_and_i = 1'b1;
    bus.cache_req_v_i       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cache_req_i = mk_req(e_uc_store, 40'h2000 + 40'(8 * i), 64'h5000 + 64'(i));
      #1 chk($sformatf("st_yumi%0d", i), 64'(bus.cache_req_yumi_o), 64'd1);
      cyc();
      #1;
      chk($sformatf("st_cmd_v%0d", i), 64'(bus.mem_cmd_v_o), 64'd1);
      chk($sformatf("st_cmd_op%0d", i), 64'(bus.mem_cmd_o.opcode), 64'(e_mem_uc_wr));
      chk($sformatf("st_cmd_data%0d", i), 64'(bus.mem_cmd_o.data), 64'h5000 + 64'(i));
      chk($sformatf("st_id%0d", i), 64'(bus.cache_req_id_o), 64'((3 + i) % 4));
      cyc();
    end
    bus.cache_req_i = mk_req(e_uc_store, 40'h3000, 64'h55);
    #1;
    chk("full_flag", 64'(bus.cache_req_credits_full_o), 64'd1);
    chk("full_no_yumi", 64'(bus.cache_req_yumi_o), 64'd0);
    cyc();
    #1 chk("full_no_yumi2", 64'(bus.cache_req_yumi_o), 64'd0);
    bus.mem_resp_v_i = 1'b1;
    #1;
    chk("ack_yumi", 64'(bus.mem_resp_yumi_o), 64'd1);
    chk("ack_req_blocked", 64'(bus.cache_req_yumi_o), 64'd0);
    cyc();
    bus.mem_resp_v_i = 1'b0;
    #1;
    chk("freed_full", 64'(bus.cache_req_credits_full_o), 64'd0);
    chk("fifth_yumi", 64'(bus.cache_req_yumi_o), 64'd1);
    cyc();
    // fifth store's command handshake coincides with a store ack: net zero
    bus.cache_req_v_i = 1'b0;
    bus.mem_resp_v_i  = 1'b1;
    #1;
    chk("simul_cmd_v", 64'(bus.mem_cmd_v_o), 64'd1);
    chk("simul_ack_yumi", 64'(bus.mem_resp_yumi_o), 64'd1);
    cyc();
    bus.mem_resp_v_i        = 1'b0;
    bus.mem_cmd_ready_and_i = 1'b0;
    #1;
    chk("simul_full", 64'(bus.cache_req_credits_full_o), 64'd0);
    chk("simul_lock", 64'(bus.cache_req_lock_o), 64'd0);
    // three credits remain outstanding: two acks leave one, the third empties
    bus.mem_resp_v_i = 1'b1;
    cyc(); cyc();
    bus.mem_resp_v_i = 1'b0;
    #1 chk("ack2_empty", 64'(bus.cache_req_credits_empty_o), 64'd0);
    bus.mem_resp_v_i = 1'b1;
    cyc();
    bus.mem_resp_v_i = 1'b0;
    #1 chk("ack3_empty", 64'(bus.cache_req_credits_empty_o), 64'd1);

    // ---------------- reset in the middle of a fill (beat 4 presented, not taken)
    bus.cache_req_v_i = 1'b1;
    bus.cache_req_i   = mk_req(e_miss_load, 40'h2040, 64'h0);
    #1 chk("r_yumi", 64'(bus.cache_req_yumi_o), 64'd1);
    cyc();
    bus.cache_req_v_i          = 1'b0;
    bus.cache_req_metadata_v_i = 1'b1;
    bus.cache_req_metadata_i   = 3'd5;
    cyc();
    bus.cache_req_metadata_v_i = 1'b0;
    bus.mem_cmd_ready_and_i    = 1'b1;
    cyc();
    bus.mem_cmd_ready_and_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bus.mem_resp_v_i        = 1'b1;
      bus.mem_resp_data_i     = 64'(n);
      bus.data_mem_pkt_yumi_i = 1'b1;
      #1 chk($sformatf("r_idx%0d", n), 64'(bus.data_mem_pkt_o.fill_index), 64'(n));
      cyc();
    end
    bus.data_mem_pkt_yumi_i = 1'b0;
    #1 chk("r_beat4_v", 64'(bus.data_mem_pkt_v_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_data_v", 64'(bus.data_mem_pkt_v_o), 64'd0);
    chk("ar_lock", 64'(bus.cache_req_lock_o), 64'd0);
    chk("ar_resp_yumi", 64'(bus.mem_resp_yumi_o), 64'd0);
    chk("ar_empty", 64'(bus.cache_req_credits_empty_o), 64'd1);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    chk("post_lock", 64'(bus.cache_req_lock_o), 64'd0);
    chk("post_empty", 64'(bus.cache_req_credits_empty_o), 64'd1);
    chk("post_id", 64'(bus.cache_req_id_o), 64'd0);
    bus.cache_req_v_i = 1'b1;
    bus.cache_req_i   = mk_req(e_uc_store, 40'h4000, 64'h7);
    #1 chk("post_yumi", 64'(bus.cache_req_yumi_o), 64'd1);
    cyc();
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
